// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared command codes, register indices, error codes, byte selects and FSM states
package i2c_seq_pkg;
  localparam logic [2:0] CMD_START     = 3'b000;
  localparam logic [2:0] CMD_WRITE     = 3'b001;
  localparam logic [2:0] CMD_READ_ACK  = 3'b010;
  localparam logic [2:0] CMD_READ_NACK = 3'b011;
  localparam logic [2:0] CMD_STOP      = 3'b100;
  localparam logic [2:0] CMD_RESTART   = 3'b101;
  localparam logic [1:0] REG_STATUS  = 2'b00;
  localparam logic [1:0] REG_DIVIDER = 2'b01;
  localparam logic [1:0] REG_CMD     = 2'b10;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [2:0] BS_ZERO  = 3'd0;
  localparam logic [2:0] BS_DEV_W = 3'd1;
  localparam logic [2:0] BS_REG   = 3'd2;
  localparam logic [2:0] BS_DATA  = 3'd3;
  localparam logic [2:0] BS_DEV_R = 3'd4;
  typedef enum logic [2:0] {
    S_INIT_DIV, S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_READY, S_CHECK, S_DONE
  } state_t;
endpackage

// File: rtl/i2c_seq_rom.sv
// i2c_seq_rom: step program, (rw, step) -> (cmd, byte select, last); STOP is the default/last step
module i2c_seq_rom
  import i2c_seq_pkg::*;
(
  input  logic       rw,
  input  logic [2:0] step,
  output logic [2:0] cmd,
  output logic [2:0] bsel,
  output logic       last
);
  always_comb begin
    cmd  = CMD_STOP;
    bsel = BS_ZERO;
    last = 1'b1;
    case ({rw, step})
      4'b0_000, 4'b1_000: begin cmd = CMD_START; last = 1'b0; end
      4'b0_001, 4'b1_001: begin cmd = CMD_WRITE; bsel = BS_DEV_W; last = 1'b0; end
      4'b0_010, 4'b1_010: begin cmd = CMD_WRITE; bsel = BS_REG; last = 1'b0; end
      4'b0_011:           begin cmd = CMD_WRITE; bsel = BS_DATA; last = 1'b0; end
      4'b1_011:           begin cmd = CMD_RESTART; last = 1'b0; end
      4'b1_100:           begin cmd = CMD_WRITE; bsel = BS_DEV_R; last = 1'b0; end
      4'b1_101:           begin cmd = CMD_READ_NACK; last = 1'b0; end
      default:            ;
    endcase
  end
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: host register read/write txns -> i2c_module bus (cs/read/write/reg_address/write_data, status on read_data)
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] DIVIDER = 16'd250,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [7:0]  rd_data,
  output logic        cs,
  output logic        read,
  output logic        write,
  output logic [1:0]  reg_address,
  output logic [15:0] write_data,
  input  logic [15:0] read_data
);
  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] to_q, to_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  hold_q, hold_d, rd_q;
  logic        rw_q, busy_q, done_q, cs_q, read_q, write_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wd_q;
  logic [1:0]  ra_q, ra_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_wr, is_rd;
  logic [2:0]  cmd, bsel;
  logic        last;
  logic [7:0]  cmd_byte;
  logic        unused_status;
  assign unused_status = ^read_data[15:10];
  i2c_seq_rom u_rom (.rw(rw_q), .step(step_q), .cmd(cmd), .bsel(bsel), .last(last));
  always_comb begin
    cmd_byte = bsel == BS_DEV_W ? {dev_q, 1'b0} :
               bsel == BS_REG   ? reg_q :
               bsel == BS_DATA  ? wd_q :
               bsel == BS_DEV_R ? {dev_q, 1'b1} : 8'h00;
    is_wr    = state_q == S_INIT_DIV || state_q == S_ISSUE;
    is_rd    = state_q == S_WAIT_BUSY || state_q == S_WAIT_READY;
    ra_d     = state_q == S_INIT_DIV ? REG_DIVIDER : state_q == S_ISSUE ? REG_CMD : REG_STATUS;
    wdata_d  = state_q == S_INIT_DIV ? DIVIDER : state_q == S_ISSUE ? {5'b0, cmd, cmd_byte} : wdata_q;
  end
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    to_d    = to_q;
    err_d   = err_q;
    hold_d  = hold_q;
    case (state_q)
      S_INIT_DIV: state_d = S_IDLE;
      S_IDLE: if (start) begin
        state_d = S_ISSUE;
        step_d  = 3'd0;
        err_d   = ERR_OK;
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        to_d    = 16'd0;
      end
      S_WAIT_BUSY, S_WAIT_READY: begin
        to_d = to_q + 16'd1;
        // >= rather than == so a count that stepped past TIMEOUT still aborts
        if (state_q == S_WAIT_BUSY ? !read_data[8] : read_data[8])
          state_d = state_q == S_WAIT_BUSY ? S_WAIT_READY : S_CHECK;
        else if (to_d >= TIMEOUT) begin
          state_d = S_DONE;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_CHECK: if (last) state_d = S_DONE;
      else begin
        state_d = S_ISSUE;
        hold_d  = cmd == CMD_READ_NACK ? read_data[7:0] : hold_q;
        if (cmd == CMD_WRITE && !read_data[9]) begin
          err_d  = ERR_NACK;
          step_d = rw_q ? 3'd6 : 3'd4;
        end else step_d = step_q + 3'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_INIT_DIV;
    endcase
  end
  // bus outputs are registered from the current state, so each strobe appears one cycle after its state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT_DIV;
      step_q  <= '0;
      to_q    <= '0;
      err_q   <= '0;
      hold_q  <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ra_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      to_q    <= to_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      if (state_q == S_IDLE && start) begin
        rw_q  <= rw;
        dev_q <= dev_addr;
        reg_q <= reg_addr;
        wd_q  <= wr_data;
      end
      if (state_d == S_DONE && err_d == ERR_OK && rw_q) rd_q <= hold_q;
      busy_q  <= state_d inside {S_ISSUE, S_WAIT_BUSY, S_WAIT_READY, S_CHECK};
      done_q  <= state_d == S_DONE;
      cs_q    <= is_wr | is_rd;
      write_q <= is_wr;
      read_q  <= is_rd;
      ra_q    <= ra_d;
      wdata_q <= wdata_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rd_data     = rd_q;
  assign cs          = cs_q;
  assign read        = read_q;
  assign write       = write_q;
  assign reg_address = ra_q;
  assign write_data  = wdata_q;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: table + random + corner-case checks against an i2c_module model and a program-list reference
module tb_i2c_txn_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, rw = 1'b0;
  logic [6:0]  dev_addr = '0;
  logic [7:0]  reg_addr = '0, wr_data = '0;
  logic        busy, done, cs, read, write;
  logic [1:0]  err, reg_address;
  logic [7:0]  rd_data;
  logic [15:0] write_data, read_data;
  always #5 clk = ~clk;
  i2c_txn_sequencer #(.TIMEOUT(16'd100)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err), .rd_data(rd_data), .cs(cs), .read(read),
    .write(write), .reg_address(reg_address), .write_data(write_data), .read_data(read_data)
  );
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask
  logic        m_ready = 1'b1, m_ack = 1'b1;
  logic [7:0]  m_dout = '0, m_rbyte = '0;
  int          m_cnt = 0, m_wcount = 0, m_delay = 2, m_nack_idx = -1;
  bit          m_stuck = 1'b0;
  logic [15:0] cmd_log[$], div_log[$], exp_q[$];
  assign read_data = {6'b0, m_ack, m_ready & !m_stuck, m_dout};
  always @(posedge clk) begin
    if (cs && write && reg_address == 2'b01) div_log.push_back(write_data);
    if (cs && write && reg_address == 2'b10) begin
      cmd_log.push_back(write_data);
      m_ready <= 1'b0;
      m_cnt   <= m_delay;
      if (write_data[10:8] == 3'b000) m_wcount <= 0;
      if (write_data[10:8] == 3'b001) begin
        m_ack    <= (m_wcount != m_nack_idx);
        m_wcount <= m_wcount + 1;
      end
      if (write_data[10:8] == 3'b011) m_dout <= m_rbyte;
    end else if (!m_ready) begin
      if (m_cnt <= 1) m_ready <= 1'b1;
      m_cnt <= m_cnt - 1;
    end
  end
  function automatic void ref_model(input logic r, input logic [6:0] d, input logic [7:0] a,
                                    input logic [7:0] w, input int nidx, output logic [1:0] e);
    logic [15:0] prog[$];
    int nw = 0;
    exp_q.delete();
    e = 2'b00;
    if (r) prog = '{16'h0000, {8'h01, d, 1'b0}, {8'h01, a}, 16'h0500, {8'h01, d, 1'b1}, 16'h0300, 16'h0400};
    else   prog = '{16'h0000, {8'h01, d, 1'b0}, {8'h01, a}, {8'h01, w}, 16'h0400};
    foreach (prog[i]) begin
      exp_q.push_back(prog[i]);
      if (prog[i][10:8] == 3'b001) begin
        if (nw == nidx) begin
          exp_q.push_back(16'h0400);
          e = 2'b01;
          return;
        end
        nw++;
      end
    end
  endfunction
  task automatic run_txn(input logic r, input logic [6:0] d, input logic [7:0] a, input logic [7:0] w,
                         output int reads);
    bit seen = 1'b0;
    reads = 0;
    cmd_log.delete();
    rw = r; dev_addr = d; reg_addr = a; wr_data = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (cs && read) reads++;
      seen = done;
    end
    chk("done_seen", seen, 1);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask
  task automatic check_words(input string tag);
    chk({tag, "_count"}, cmd_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), cmd_log[i], exp_q[i]);
  endtask
  typedef struct {
    logic r; logic [6:0] d; logic [7:0] a; logic [7:0] w; logic [7:0] rb;
    int nidx; int n; logic [15:0] words[7]; logic [1:0] e; logic [7:0] rd;
  } vec_t;
  vec_t tbl[7];
  initial begin
    int reads, n;
    logic [1:0] e;
    logic [7:0] exp_rd;
    logic r; logic [6:0] d; logic [7:0] a, w, rb;
    int nidx;
    tbl[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 5, '{16'h0000, 16'h01A0, 16'h0110, 16'h01A5, 16'h0400, 16'h0, 16'h0}, 2'b00, 8'h00};
    tbl[1] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, 7, '{16'h0000, 16'h01A0, 16'h0122, 16'h0500, 16'h01A1, 16'h0300, 16'h0400}, 2'b00, 8'h3C};
    tbl[2] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h77, 0, 3, '{16'h0000, 16'h01A0, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0}, 2'b01, 8'h3C};
    tbl[3] = '{1'b0, 7'h2B, 8'h07, 8'h5A, 8'h00, 2, 5, '{16'h0000, 16'h0156, 16'h0107, 16'h015A, 16'h0400, 16'h0, 16'h0}, 2'b01, 8'h3C};
    tbl[4] = '{1'b1, 7'h7F, 8'hFF, 8'h00, 8'h99, 1, 4, '{16'h0000, 16'h01FE, 16'h01FF, 16'h0400, 16'h0, 16'h0, 16'h0}, 2'b01, 8'h3C};
    tbl[5] = '{1'b0, 7'h00, 8'h00, 8'hFF, 8'h00, -1, 5, '{16'h0000, 16'h0100, 16'h0100, 16'h01FF, 16'h0400, 16'h0, 16'h0}, 2'b00, 8'h3C};
    tbl[6] = '{1'b1, 7'h01, 8'h80, 8'h00, 8'h00, -1, 7, '{16'h0000, 16'h0102, 16'h0180, 16'h0500, 16'h0103, 16'h0300, 16'h0400}, 2'b00, 8'h00};
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_write_data", write_data, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("div_write_count", div_log.size(), 1);
    if (div_log.size() > 0) chk("div_value", div_log[0], 16'd250);
    chk("init_busy", busy, 0);
    chk("init_err", err, 0);
    chk("init_rd_data", rd_data, 0);
    chk("init_no_cmd", cmd_log.size(), 0);
    foreach (tbl[i]) begin
      m_nack_idx = tbl[i].nidx;
      m_rbyte = tbl[i].rb;
      m_delay = 1 + i % 3;
      run_txn(tbl[i].r, tbl[i].d, tbl[i].a, tbl[i].w, reads);
      exp_q.delete();
      for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].words[j]);
      check_words($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_err", i), err, tbl[i].e);
      chk($sformatf("vec%0d_rd", i), rd_data, tbl[i].rd);
    end
    exp_rd = 8'h00;
    for (int k = 0; k < 20; k++) begin
      r = 1'($urandom_range(0, 1));
      d = 7'($urandom);
      a = 8'($urandom);
      w = 8'($urandom);
      rb = 8'($urandom);
      nidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      m_nack_idx = nidx;
      m_rbyte = rb;
      m_delay = int'($urandom_range(0, 4));
      ref_model(r, d, a, w, nidx, e);
      if (r && e == 2'b00) exp_rd = rb;
      run_txn(r, d, a, w, reads);
      check_words($sformatf("rnd%0d", k));
      chk($sformatf("rnd%0d_err", k), err, e);
      chk($sformatf("rnd%0d_rd", k), rd_data, exp_rd);
    end
    m_stuck = 1'b1;
    m_nack_idx = -1;
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, reads);
    m_stuck = 1'b0;
    chk("timeout_wait_cycles", reads, 100);
    chk("timeout_err", err, 2'b10);
    chk("timeout_cmd_count", cmd_log.size(), 1);
    if (cmd_log.size() > 0) chk("timeout_only_start", cmd_log[0], 16'h0000);
    chk("timeout_rd_kept", rd_data, exp_rd);
    repeat (10) @(negedge clk);
    m_rbyte = 8'hC3;
    m_delay = 2;
    run_txn(1'b1, 7'h12, 8'h34, 8'h00, reads);
    chk("read_c3_err", err, 0);
    chk("read_c3_rd", rd_data, 8'hC3);
    cmd_log.delete();
    m_delay = 3;
    rw = 1'b1; dev_addr = 7'h11; reg_addr = 8'h44; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rw = 1'b0; dev_addr = 7'h33; reg_addr = 8'h55; wr_data = 8'h66; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && cmd_log.size() < 4; i++) @(negedge clk);
    chk("midread_progress", cmd_log.size() >= 4, 1);
    exp_q = '{16'h0000, 16'h0122, 16'h0144, 16'h0500};
    for (int i = 0; i < 4 && i < cmd_log.size(); i++)
      chk($sformatf("midread_w%0d", i), cmd_log[i], exp_q[i]);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_rd", rd_data, 0);
    chk("abort_strobes", {cs, read, write}, 0);
    chk("abort_reg_address", reg_address, 0);
    chk("abort_write_data", write_data, 0);
    n = cmd_log.size();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rediv_count", div_log.size(), 2);
    if (div_log.size() > 1) chk("rediv_value", div_log[1], 16'd250);
    chk("abort_no_stop", cmd_log.size(), n);
    chk("post_abort_busy", busy, 0);
    m_nack_idx = -1;
    ref_model(1'b0, 7'h50, 8'h10, 8'hA5, -1, e);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, reads);
    check_words("post_abort");
    chk("post_abort_err", err, e);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
